// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA encodings, ALU codes and the control-vector type for the
// ID stage: the decoder and the ID/EX register both use this vector.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL      = 6'h00;
  localparam logic [5:0] FN_SRL      = 6'h02;
  localparam logic [5:0] FN_JR       = 6'h08;
  localparam logic [5:0] FN_MUL      = 6'h18;
  localparam logic [5:0] FN_ADD      = 6'h20;
  localparam logic [5:0] FN_SUB      = 6'h22;
  localparam logic [5:0] FN_AND      = 6'h24;
  localparam logic [5:0] FN_OR       = 6'h25;
  localparam logic [5:0] FN_XOR      = 6'h26;
  localparam logic [5:0] FN_NOR      = 6'h27;
  localparam logic [5:0] FN_SLT      = 6'h2A;
  localparam logic [5:0] FN2_MUL     = 6'h02;

  localparam logic [4:0] RT_BLTZ     = 5'd0;
  localparam logic [4:0] RT_BGEZ     = 5'd1;

  localparam logic [5:0] ALU_AND   = 6'd0;
  localparam logic [5:0] ALU_OR    = 6'd1;
  localparam logic [5:0] ALU_XOR   = 6'd2;
  localparam logic [5:0] ALU_NOR   = 6'd3;
  localparam logic [5:0] ALU_ADD   = 6'd4;
  localparam logic [5:0] ALU_SUB   = 6'd5;
  localparam logic [5:0] ALU_MUL   = 6'd6;
  localparam logic [5:0] ALU_SLT   = 6'd7;
  localparam logic [5:0] ALU_SLL   = 6'd8;
  localparam logic [5:0] ALU_SRL   = 6'd9;
  localparam logic [5:0] ALU_BEQ   = 6'd10;
  localparam logic [5:0] ALU_BNE   = 6'd11;
  localparam logic [5:0] ALU_BGTZ  = 6'd12;
  localparam logic [5:0] ALU_BGEZ  = 6'd13;
  localparam logic [5:0] ALU_BLTZ  = 6'd14;
  localparam logic [5:0] ALU_BLEZ  = 6'd15;
  localparam logic [5:0] ALU_PASSA = 6'd16;
  localparam logic [5:0] ALU_PASSB = 6'd17;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [1:0] MSZ_BYTE = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } reg_dst_e;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       ext_zero;
    logic       use_shamt;
    logic       mem_unsigned;
    logic [1:0] wb_source;
    logic [1:0] mem_size;
    logic [5:0] alu_control;
    reg_dst_e   reg_dst;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    alu_src:      1'b0,
    reg_write:    1'b0,
    mem_read:     1'b0,
    mem_write:    1'b0,
    branch:       1'b0,
    jump:         1'b0,
    jump_reg:     1'b0,
    ext_zero:     1'b0,
    use_shamt:    1'b0,
    mem_unsigned: 1'b0,
    wb_source:    WB_ALU,
    mem_size:     MSZ_WORD,
    alu_control:  ALU_ADD,
    reg_dst:      DST_RT
  };

endpackage

// File: rtl/id_control_stage_if.sv
// IF/ID-side inputs and registered ID/EX outputs of the ID control stage.
interface id_control_stage_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic        ex_alu_src;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_jump_reg;
  logic        ex_ext_zero;
  logic        ex_use_shamt;
  logic        ex_mem_unsigned;
  logic [1:0]  ex_wb_source;
  logic [1:0]  ex_mem_size;
  logic [5:0]  ex_alu_control;
  logic [4:0]  ex_dest_reg;
  logic        ex_illegal;

  modport master (
    output instr_valid, instruction, flush,
    input  stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_jump_reg, ex_ext_zero, ex_use_shamt,
           ex_mem_unsigned, ex_wb_source, ex_mem_size, ex_alu_control,
           ex_dest_reg, ex_illegal
  );

  modport slave (
    input  instr_valid, instruction, flush,
    output stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_jump_reg, ex_ext_zero, ex_use_shamt,
           ex_mem_unsigned, ex_wb_source, ex_mem_size, ex_alu_control,
           ex_dest_reg, ex_illegal
  );
endinterface

// File: rtl/control_decode.sv
// Combinational MIPS decoder: opcode/REGIMM-rt/funct -> control vector,
// register-source usage flags, multiply and illegal indications.
module control_decode
  import mips_isa_pkg::*;
#(
  parameter bit ENABLE_HALF = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [4:0] rt_field,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       rs_used,
  output logic       rt_used,
  output logic       is_mul,
  output logic       illegal
);

  logic  bad;
  ctrl_t dec;

  always_comb begin
    dec = BUBBLE;
    bad = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = DST_RD;
        unique case (funct)
          FN_ADD: dec.alu_control = ALU_ADD;
          FN_SUB: dec.alu_control = ALU_SUB;
          FN_AND: dec.alu_control = ALU_AND;
          FN_OR:  dec.alu_control = ALU_OR;
          FN_XOR: dec.alu_control = ALU_XOR;
          FN_NOR: dec.alu_control = ALU_NOR;
          FN_SLT: dec.alu_control = ALU_SLT;
          FN_MUL: dec.alu_control = ALU_MUL;
          FN_SLL: begin
            dec.alu_control = ALU_SLL;
            dec.use_shamt   = 1'b1;
          end
          FN_SRL: begin
            dec.alu_control = ALU_SRL;
            dec.use_shamt   = 1'b1;
          end
          FN_JR: begin
            dec.reg_write   = 1'b0;
            dec.alu_control = ALU_PASSA;
            dec.jump        = 1'b1;
            dec.jump_reg    = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        dec.reg_write   = 1'b1;
        dec.reg_dst     = DST_RD;
        dec.alu_control = ALU_MUL;
        if (funct != FN2_MUL) bad = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        unique case (opcode)
          OP_SLTI: dec.alu_control = ALU_SLT;
          OP_ANDI: dec.alu_control = ALU_AND;
          OP_ORI:  dec.alu_control = ALU_OR;
          OP_XORI: dec.alu_control = ALU_XOR;
          default: dec.alu_control = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.wb_source = WB_MEM;
        dec.mem_size  = (opcode == OP_LB) ? MSZ_BYTE :
                        (opcode == OP_LH) ? MSZ_HALF : MSZ_WORD;
        if (opcode == OP_LH && !ENABLE_HALF) bad = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size  = (opcode == OP_SB) ? MSZ_BYTE :
                        (opcode == OP_SH) ? MSZ_HALF : MSZ_WORD;
        if (opcode == OP_SH && !ENABLE_HALF) bad = 1'b1;
      end
      OP_BEQ:  begin dec.branch = 1'b1; dec.alu_control = ALU_BEQ;  end
      OP_BNE:  begin dec.branch = 1'b1; dec.alu_control = ALU_BNE;  end
      OP_BLEZ: begin dec.branch = 1'b1; dec.alu_control = ALU_BLEZ; end
      OP_BGTZ: begin dec.branch = 1'b1; dec.alu_control = ALU_BGTZ; end
      OP_REGIMM: begin
        dec.branch = 1'b1;
        if (rt_field == RT_BLTZ)      dec.alu_control = ALU_BLTZ;
        else if (rt_field == RT_BGEZ) dec.alu_control = ALU_BGEZ;
        else                          bad = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.reg_dst     = DST_RA;
        dec.wb_source   = WB_PC4;
        dec.alu_control = ALU_PASSB;
      end
      default: bad = 1'b1;
    endcase
  end

  // An undecodable word reads no registers, so it can never cause a stall.
  assign ctrl    = bad ? BUBBLE : dec;
  assign illegal = bad;
  assign is_mul  = !bad && (dec.alu_control == ALU_MUL);
  assign rs_used = !bad && !(opcode == OP_J || opcode == OP_JAL) && !dec.use_shamt;
  assign rt_used = !bad && (opcode == OP_RTYPE || opcode == OP_SPECIAL2 ||
                            opcode == OP_BEQ || opcode == OP_BNE || dec.mem_write);

endmodule

// File: rtl/id_control_stage.sv
// Pipelined ID control: decode into the ID/EX register, load-use and
// multiply-busy stalls, flush squash and destination resolution.
module id_control_stage
  import mips_isa_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter bit ENABLE_HALF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  id_control_stage_if.slave bus
);

  localparam int CW = $clog2(MUL_LATENCY + 1);

  ctrl_t          dec_ctrl;
  logic           rs_used, rt_used, dec_mul, dec_illegal;
  logic [4:0]     rs, rt, rd, dec_dest;
  ctrl_t          ex_ctrl;
  logic           ex_valid, ex_illegal;
  logic [4:0]     ex_dest;
  logic [CW-1:0]  mul_cnt;
  logic           mul_busy, load_use;

  assign rs = bus.instruction[25:21];
  assign rt = bus.instruction[20:16];
  assign rd = bus.instruction[15:11];

  control_decode #(.ENABLE_HALF(ENABLE_HALF)) u_decode (
    .opcode   (bus.instruction[31:26]),
    .rt_field (rt),
    .funct    (bus.instruction[5:0]),
    .ctrl     (dec_ctrl),
    .rs_used  (rs_used),
    .rt_used  (rt_used),
    .is_mul   (dec_mul),
    .illegal  (dec_illegal)
  );

  always_comb begin
    dec_dest = rt;
    unique case (dec_ctrl.reg_dst)
      DST_RD:  dec_dest = rd;
      DST_RA:  dec_dest = 5'd31;
      default: dec_dest = rt;
    endcase
    if (!dec_ctrl.reg_write) dec_dest = 5'd0;
  end

  assign mul_busy = (mul_cnt != '0);
  assign load_use = ex_valid && ex_ctrl.mem_read && (ex_dest != 5'd0) && bus.instr_valid &&
                    ((rs_used && rs == ex_dest) || (rt_used && rt == ex_dest));
  assign bus.stall = !bus.flush && (mul_busy || load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl    <= BUBBLE;
      ex_valid   <= 1'b0;
      ex_dest    <= 5'd0;
      ex_illegal <= 1'b0;
      mul_cnt    <= '0;
    end else begin
      ex_ctrl    <= BUBBLE;
      ex_valid   <= 1'b0;
      ex_dest    <= 5'd0;
      ex_illegal <= 1'b0;
      if (bus.flush) begin
        mul_cnt <= '0;
      end else if (mul_busy) begin
        mul_cnt <= mul_cnt - CW'(1);
      end else if (!load_use && bus.instr_valid) begin
        if (dec_illegal) begin
          ex_illegal <= 1'b1;
        end else begin
          ex_ctrl  <= dec_ctrl;
          ex_valid <= 1'b1;
          ex_dest  <= dec_dest;
          // The multiply itself counts as the first of its EX cycles.
          if (dec_mul) mul_cnt <= CW'(MUL_LATENCY - 1);
        end
      end
    end
  end

  assign bus.ex_valid        = ex_valid;
  assign bus.ex_alu_src      = ex_ctrl.alu_src;
  assign bus.ex_reg_write    = ex_ctrl.reg_write;
  assign bus.ex_mem_read     = ex_ctrl.mem_read;
  assign bus.ex_mem_write    = ex_ctrl.mem_write;
  assign bus.ex_branch       = ex_ctrl.branch;
  assign bus.ex_jump         = ex_ctrl.jump;
  assign bus.ex_jump_reg     = ex_ctrl.jump_reg;
  assign bus.ex_ext_zero     = ex_ctrl.ext_zero;
  assign bus.ex_use_shamt    = ex_ctrl.use_shamt;
  assign bus.ex_mem_unsigned = ex_ctrl.mem_unsigned;
  assign bus.ex_wb_source    = ex_ctrl.wb_source;
  assign bus.ex_mem_size     = ex_ctrl.mem_size;
  assign bus.ex_alu_control  = ex_ctrl.alu_control;
  assign bus.ex_dest_reg     = ex_dest;
  assign bus.ex_illegal      = ex_illegal;

endmodule

// File: doc/id_control_stage.md
# id_control_stage

Pipelined successor to the single-cycle MIPS controller. It decodes the instruction held in IF/ID into the same control vector and ALU codes, registers that vector into the ID/EX boundary, and resolves the destination register. It also detects load-use hazards, holds the front end for multi-cycle multiplies, and squashes the ID slot on a taken branch or jump. It sits between the IF/ID pipeline register and the EX stage.

## Interface
- MUL_LATENCY, 3, EX cycles a multiply occupies (≥1).
- ENABLE_HALF, 1, 1 = lh/sh decoded; 0 = lh/sh treated as illegal.
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- InstrValid  in  1  IF/ID holds a real instruction.
- Instruction  in  32  IF/ID instruction word.
- Flush  in  1  taken branch/jump resolved in EX; squash the ID slot.
- Stall  out  1  combinational; hold PC and IF/ID this cycle.
- ExValid  out  1  ID/EX slot holds a real instruction.
- ExALUSrc, ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExJump, ExJumpReg, ExExtZero, ExUseShamt, ExMemUnsigned  out  1 each  registered control bits.
- ExWBSource  out  2  00 ALU, 01 memory, 10 PC+4.
- ExMemSize  out  2  00 byte, 01 half, 10 word.
- ExALUControl  out  6  ALU codes 0–17: AND, OR, XOR, NOR, ADD, SUB, MUL, SLT, SLL, SRL, BEQ, BNE, BGTZ, BGEZ, BLTZ, BLEZ, PASSA, PASSB.
- ExDestReg  out  5  resolved destination: rt, rd or 31; 0 when RegWrite is 0.
- ExIllegal  out  1  one-cycle flag; the instruction entering EX was undecodable.

## Operation
- **Decode set.** Decode is unchanged from the existing control set:
  - R-type: add, sub, and, or, xor, nor, slt, mul (funct 0x18), sll/srl (UseShamt), jr (PASSA, Jump, JumpReg).
  - SPECIAL2 mul (funct 0x02).
  - Immediates: addi, slti (sign-extended); andi, ori, xori (zero-extended).
  - Memory: lw, lb, lh, sw, sb, sh.
  - Branches: beq, bne, blez, bgtz, bltz/bgez (REGIMM).
  - Jumps: j; jal (dest 31, WB PC+4, PASSB).
- **Bubble vector.** All control bits 0, ALUControl = ADD, MemSize = word, ExDestReg = 0, ExValid = 0.
- **Source usage.**
  - rs is a source for everything except j, jal, sll and srl.
  - rt is a source for R-type, beq, bne and stores.
- **Per-cycle priority** (highest first):
  1. Flush: bubble into EX, clear the multiply counter, Stall = 0.
  2. Multiply busy (counter ≠ 0): bubble into EX, Stall = 1, decrement the counter.
  3. Load-use: ExValid && ExMemRead && ExDestReg ≠ 0 && InstrValid && ExDestReg matches a used source. Bubble into EX and Stall = 1 for exactly one cycle.
  4. Otherwise: register the decoded vector, with ExValid = InstrValid.
- **Multiply issue.** When a mul issues, the counter loads MUL_LATENCY−1. With MUL_LATENCY = 1 no stall cycles occur.
- **Illegal instructions.** An unknown opcode, funct or REGIMM rt, or lh/sh with ENABLE_HALF = 0, issues a bubble and sets ExIllegal = 1 for that cycle.
- **Invalid slot.** InstrValid = 0 issues a bubble and never causes a stall.
- **Register 0.** A destination of register 0 is written through as 0 and never triggers load-use.

## Timing
- ID→EX latency is one cycle. Every Ex* output is a flop.
- Stall is combinational from the Ex* registers, the counter and Instruction.
  - No Clk-to-Stall path exists except through those flops.
  - Flush forces Stall = 0 in the same cycle.
- **Reset** is asynchronous; while Rst is high:
  - all Ex* outputs equal the bubble vector;
  - ExIllegal = 0;
  - counter = 0;
  - Stall = 0.
- Deassertion is synchronised externally; the first edge after release samples normally.
- **Stall duration.**
  - A load-use stall lasts one cycle; the replayed instruction issues on the next edge.
  - A mul followed by a dependent instruction stalls MUL_LATENCY−1 cycles, with no extra load-use cycle, because a mul is not MemRead.
- **Boundary cases.**
  - Flush arriving in the same cycle as load-use or multiply busy wins.
  - Rst arriving mid-stall aborts the stall immediately.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode, funct and REGIMM rt constants;
  - ALU code constants (0–17);
  - WBSource, MemSize and RegDstSel encodings;
  - the bubble-vector constant.
- Sub-module `control_decode` is a purely combinational Instruction → control-vector decoder that also produces rs/rt-used flags and an illegal flag. It is instantiated once.
- The hazard, multiply-counter and ID/EX register logic sits in the top module.

## Test plan
- **Load-use:** `lw $8,0($9)` then `add $10,$8,$11` → Stall = 1 for one cycle, bubble then add issues; ExALUControl = 4, ExDestReg = 10.
- **Multiply, MUL_LATENCY = 3:** `mul $5,$6,$7` then `add` → add enters EX after 2 bubble cycles, Stall high for 2 cycles; with MUL_LATENCY = 1 there is no stall.
- **Flush over stall:** Flush during a load-use stall → Stall = 0, ExValid = 0 on the next edge, counter = 0.
- **jal:** `jal` → ExDestReg = 31, ExWBSource = 10, ExALUControl = 17, ExRegWrite = 1; `lw $0` then `add` using $0 → no stall.
- **Illegal instruction:** opcode 0x3F → ExIllegal = 1 for one cycle, ExValid = 0; `lh` with ENABLE_HALF = 0 → ExIllegal = 1.
- **Mid-stall reset:** Rst asserted mid-multiply stall → all outputs return to the bubble vector and Stall = 0 without waiting for a clock edge.
